// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH stages of WIDTH bits with per-stage valid,
// valid/ready backpressure, bubble collapsing, synchronous flush and occupancy count.
module dff_pipe #(
  parameter int              WIDTH     = 64,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_next;
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_vld;
  logic [DEPTH-1:0] we;
  logic [WIDTH-1:0] data     [DEPTH];
  logic [WIDTH-1:0] data_src [DEPTH];
  logic [CW-1:0]    cnt_next;
  logic             accept;

  // Ready ripples back from out_ready; an empty stage is always ready, which
  // is what lets holes close up while the output is stalled.
  always_comb begin : ready_chain
    logic r;
    rdy = '0;
    r   = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r      = !vld[i] | r;
      rdy[i] = r;
    end
  end

  assign in_ready = rdy[0] & !flush;
  assign accept   = in_valid & in_ready;

  // Valid and data sources for each stage: stage 0 from upstream, others from
  // the previous stage.
  if (DEPTH == 1) begin : g_src_one
    assign src_vld = accept;
  end else begin : g_src_many
    assign src_vld = {vld[DEPTH-2:0], accept};
  end

  always_comb begin
    data_src[0] = in_data;
    for (int i = 1; i < DEPTH; i++) data_src[i] = data[i-1];
  end

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    vld_next = vld;
    we       = '0;
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rdy[i]) vld_next[i] = src_vld[i];
      we[i] = rdy[i] & src_vld[i] & !flush;
    end
    if (flush) vld_next = '0;
    for (int i = 0; i < DEPTH; i++) cnt_next = cnt_next + CW'(vld_next[i]);
  end

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      count <= '0;
    end else begin
      vld   <= vld_next;
      count <= cnt_next;
    end
  end

  // NOTE: the data registers are reset on purpose so out_data shows RESET_VAL
  // immediately; they are flops, not a RAM, so this is cheap to do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[i]) data[i] <= data_src[i];
      end
    end
  end

  assign out_valid = vld[DEPTH-1] & !flush;
  assign out_data  = data[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Directed table-driven bench for dff_pipe (WIDTH=8, DEPTH=3, RESET_VAL=A5):
// streaming, backpressure, bubble collapse, flush and asynchronous reset.
module tb_dff_pipe;

  localparam int         WIDTH = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] RV    = 8'hA5;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data   = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int tests = 0;
  int fails = 0;

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [step %0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [7:0] id, input logic ordy,
                     input logic fl, input logic ir, input logic ov,
                     input logic [7:0] od, input logic [1:0] cnt);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ir = ir; v.ov = ov; v.od = od; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, compare 1 time unit later; the rising edge
  // that follows commits the step.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    in_valid  = v.iv;
    in_data   = v.id;
    out_ready = v.ordy;
    flush     = v.fl;
    #1;
    check("in_ready",  idx, 32'(in_ready),  32'(v.ir));
    check("out_valid", idx, 32'(out_valid), 32'(v.ov));
    check("out_data",  idx, 32'(out_data),  32'(v.od));
    check("count",     idx, 32'(count),     32'(v.cnt));
  endtask

  initial begin
    // Streaming 01..0A with out_ready high: first beat out after 3 edges.
    for (int k = 0; k < 10; k++) begin
      add(1'b1, 8'(k + 1), 1'b1, 1'b0, 1'b1, k >= 3,
          (k >= 3) ? 8'(k - 2) : RV, (k >= 3) ? 2'd3 : 2'(k));
    end
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h08, 2'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h09, 2'd2);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0A, 2'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0A, 2'd0);
    // Backpressure fill: 44 refused until out_ready rises, then full
    // pipe accepts and delivers in the same cycle.
    add(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0A, 2'd0);
    add(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0A, 2'd1);
    add(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0A, 2'd2);
    add(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd3);
    add(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd3);
    add(1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 2'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 2'd2);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 2'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 2'd0);
    // Bubble collapse: B1 in stage 2, B2 in stage 0, stage 1 empty.
    add(1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 2'd0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 2'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h44, 2'd1);
    add(1'b1, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB1, 2'd1);
    add(1'b1, 8'hB3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB1, 2'd2);
    add(1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 2'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1, 2'd3);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2, 2'd2);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB3, 2'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hB3, 2'd0);
    // Flush a full pipe with in_valid and out_ready high; C4 must be dropped.
    add(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB3, 2'd0);
    add(1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB3, 2'd1);
    add(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB3, 2'd2);
    add(1'b1, 8'hC4, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC1, 2'd3);
    add(1'b1, 8'hC5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC1, 2'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC1, 2'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC1, 2'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hC5, 2'd1);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC5, 2'd0);

    // Asynchronous reset between edges, checked without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst count",     -1, 32'(count),     32'd0);
    check("rst out_valid", -1, 32'(out_valid), 32'd0);
    check("rst out_data",  -1, 32'(out_data),  32'(RV));
    check("rst in_ready",  -1, 32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i], i);

    // Mid-operation reset: two beats in flight, pulse rst_n between edges.
    begin
      vec_t v;
      v = '{iv: 1'b1, id: 8'hD1, ordy: 1'b1, fl: 1'b0,
            ir: 1'b1, ov: 1'b0, od: 8'hC5, cnt: 2'd0};
      apply(v, 100);
      v.id = 8'hD2; v.cnt = 2'd1;
      apply(v, 101);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("pre-rst count", 102, 32'(count), 32'd2);
      #1 rst_n = 1'b0;
      #1;
      check("mid-rst count",     103, 32'(count),     32'd0);
      check("mid-rst out_valid", 103, 32'(out_valid), 32'd0);
      check("mid-rst out_data",  103, 32'(out_data),  32'(RV));
      check("mid-rst in_ready",  103, 32'(in_ready),  32'd1);
      #1 rst_n = 1'b1;

      v = '{iv: 1'b1, id: 8'hE1, ordy: 1'b1, fl: 1'b0,
            ir: 1'b1, ov: 1'b0, od: RV, cnt: 2'd0};
      apply(v, 104);
      v.id = 8'hE2; v.cnt = 2'd1;
      apply(v, 105);
      v.id = 8'hE3; v.cnt = 2'd2;
      apply(v, 106);
      v.iv = 1'b0; v.id = 8'h00; v.ov = 1'b1; v.od = 8'hE1; v.cnt = 2'd3;
      apply(v, 107);
      v.od = 8'hE2; v.cnt = 2'd2;
      apply(v, 108);
      v.od = 8'hE3; v.cnt = 2'd1;
      apply(v, 109);
      v.ov = 1'b0; v.cnt = 2'd0;
      apply(v, 110);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
Parametrised elastic register pipeline. It generalises the fixed-width D flip-flop banks (1/32/63/64-bit) to a configurable WIDTH and DEPTH of stages. Each stage carries a valid bit and obeys valid/ready backpressure with bubble collapsing. The block adds an asynchronous active-low reset, a synchronous flush and an occupancy count. It is the standard retiming/stall-tolerant pipe used between datapath blocks.

Parameters:
WIDTH, 64, data bits per stage (>=1)
DEPTH, 2, number of register stages (>=1)
RESET_VAL, 0, value loaded into every data register on reset (WIDTH bits)

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all in-flight beats
in_valid  input  1  upstream beat present
in_ready  output  1  pipe accepts beat this cycle
in_data  input  WIDTH  upstream data
out_valid  output  1  beat available at output
out_ready  input  1  downstream accepts beat
out_data  output  WIDTH  data of final stage
count  output  $clog2(DEPTH+1)  number of valid stages (registered)

Behaviour:
- Stages 0..DEPTH-1; stage 0 is fed by in_*, stage DEPTH-1 drives out_*. Each stage has a vld[i] flag and data[i].
- Ready chain: rdy[DEPTH] = out_ready; rdy[i] = !vld[i] | rdy[i+1]. in_ready = rdy[0] & !flush. This is a combinational path from out_ready to in_ready and is permitted.
- Stage i captures when rdy[i] is high:
  - vld[i] <= vld[i-1] (stage 0 takes in_valid & in_ready);
  - data[i] <= data[i-1] / in_data, written only when the incoming valid is 1.
  - When rdy[i] is low, the stage holds. An emptied stage retains its last data.
- Bubble collapsing: an empty stage accepts even while downstream stalls. Holes close up one stage per cycle.
- Latency: a beat accepted at edge t is presented on out_valid/out_data after edge t+DEPTH-1 (DEPTH cycles from in_valid to out_valid in an unstalled pipe). Throughput is 1 beat/cycle when out_ready is held high.
- Data never skips a stage. Beats leave in acceptance order. There is no duplication and no loss, except by flush.
- out_valid = vld[DEPTH-1] & !flush; out_data = data[DEPTH-1].
- Output stability: once out_valid=1, out_valid and out_data stay unchanged until out_ready=1, unless flush or reset occurs.
- Upstream obligation: in_data must be stable while in_valid & !in_ready. A violation is not checked.
- flush (synchronous):
  - during the flush cycle no beat is accepted and none is delivered;
  - after the edge all vld=0 and count=0;
  - data registers are unchanged;
  - flush overrides in_valid and out_ready in the same cycle.
- count: registered. Next value = popcount of next vld vector. Simultaneous accept and deliver leaves count unchanged. Range 0..DEPTH.
- Full: count==DEPTH and out_ready=0 gives in_ready=0. Full with out_ready=1 gives in_ready=1, and accept and deliver happen in the same cycle.
- Reset (rst_n=0, asynchronous, any time including mid-transfer):
  - immediately all vld=0, data=RESET_VAL, count=0;
  - hence out_valid=0, out_data=RESET_VAL;
  - in_ready=1 if flush=0.
  - The first capture occurs on the first rising clk edge after rst_n deasserts.
- DEPTH=1 degenerates to a single backpressured register: full when vld, and passes through when out_ready=1.

Test Plan:
- Reset: WIDTH=8, DEPTH=3, RESET_VAL=8'hA5; assert rst_n=0 between edges -> out_valid=0, out_data=A5, count=0 without waiting for clk.
- Streaming: out_ready=1, push 8'h01..8'h0A on consecutive cycles -> out_valid first high 3 cycles after the first accept; values 01..0A emerge on consecutive cycles; count steady at 3.
- Backpressure fill: out_ready=0, push 11,22,33,44 -> 11,22,33 accepted; in_ready=0 when 44 is offered; count=3; out_data=11 held. Raise out_ready -> 11,22,33,44 delivered in order.
- Bubble collapse: DEPTH=3, beats in stages 2 and 0 with stage 1 empty, out_ready=0, in_valid=1 -> in_ready=1; after the edge stages are full and count=3.
- Flush: pipe holds 3 beats, assert flush with in_valid=1 and out_ready=1 -> in_ready=0 and out_valid=0 that cycle; next cycle count=0; the offered beat is not accepted.
- Mid-operation reset: streaming with count=2, pulse rst_n low for half a cycle -> count=0 and out_valid=0 asynchronously; subsequent beats emerge with DEPTH latency and no stale data.
